// File: rtl/register_file_mp.sv
// Multi-read-port register file with optional write-to-read bypass and a
// per-register pending-write (busy) scoreboard; register 0 is constant zero.
module register_file_mp #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_READ = 2,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [XLEN-1:0]          wr_data,
  input  logic [NUM_READ*AW-1:0]   rd_addr,
  output logic [NUM_READ*XLEN-1:0] rd_data,
  output logic [NUM_READ-1:0]      rd_busy,
  input  logic                     issue_en,
  input  logic [AW-1:0]            issue_rd,
  output logic                     any_busy
);

  logic [XLEN-1:0]     r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_next;
  logic                w_wr_valid;
  logic                w_iss_valid;

  assign w_wr_valid  = wr_en && (wr_addr != '0);
  assign w_iss_valid = issue_en && (issue_rd != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_valid) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  // Set is applied after clear so a new producer supersedes the retiring one.
  always_comb begin
    w_busy_next = r_busy;
    if (w_wr_valid) begin
      w_busy_next[wr_addr] = 1'b0;
    end
    if (w_iss_valid) begin
      w_busy_next[issue_rd] = 1'b1;
    end
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  assign any_busy = !rst && (|r_busy);

  for (genvar g = 0; g < NUM_READ; g++) begin : g_rd
    logic [AW-1:0]   w_addr;
    logic            w_hit;
    logic [XLEN-1:0] w_data;
    logic            w_busy;

    assign w_addr = rd_addr[g*AW +: AW];
    assign w_hit  = (BYPASS != 0) && w_wr_valid && (wr_addr == w_addr);

    // Reset gating matters only for the bypass path; storage is already zero.
    always_comb begin
      w_data = r_regs[w_addr];
      w_busy = r_busy[w_addr];
      if (rst || (w_addr == '0)) begin
        w_data = '0;
        w_busy = 1'b0;
      end else if (w_hit) begin
        w_data = wr_data;
        w_busy = 1'b0;
      end
    end

    assign rd_data[g*XLEN +: XLEN] = w_data;
    assign rd_busy[g]              = w_busy;
  end

endmodule
